// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants: enable levels, zero payload, payload width, stage indices.
package pipe_stage_reg_pkg;

   localparam logic Enable  = 1'b1;
   localparam logic Disable = 1'b0;

   localparam int unsigned PipePayloadW = 102;
   localparam logic [PipePayloadW-1:0] ZeroWord = '0;

   // Bit positions in the shared stall-controller vector
   localparam int unsigned StageIF  = 0;
   localparam int unsigned StageID  = 1;
   localparam int unsigned StageEX  = 2;
   localparam int unsigned StageMEM = 3;
   localparam int unsigned StageWB  = 4;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; counts while inc is high, sticks at all-ones, cleared only by rst.
module pipe_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, rdy freeze, stall hold, flush and
// bubble counter. Define PIPE_STAGE_SKID_EN to add a second (skid) entry.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W  = PipePayloadW,
   parameter int unsigned STALL_W = 6,
   parameter int unsigned STAGE   = StageEX,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [STALL_W-1:0] stall_ctrler,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               out_ready,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   bubble_cnt
);

   logic              hold;
   logic              in_fire;
   logic              out_fire;
   logic              main_valid;
   logic              main_valid_d;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] main_data_d;

   assign hold     = stall_ctrler[STAGE];
   assign out_fire = main_valid & out_ready & rdy & ~flush;
   assign in_fire  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid;
   logic              skid_valid_d;
   logic [DATA_W-1:0] skid_data;
   logic [DATA_W-1:0] skid_data_d;

   // Ready depends only on local state, breaking the combinational out_ready path
   assign in_ready = ~skid_valid & ~hold & ~flush & rdy & ~rst;

   always_comb begin
      main_valid_d = main_valid;
      main_data_d  = main_data;
      skid_valid_d = skid_valid;
      skid_data_d  = skid_data;
      if (flush) begin
         main_valid_d = Disable;
         main_data_d  = '0;
         skid_valid_d = Disable;
         skid_data_d  = '0;
      end else if (out_fire) begin
         if (skid_valid) begin
            main_valid_d = Enable;
            main_data_d  = skid_data;
            skid_valid_d = Disable;
            skid_data_d  = '0;
         end else if (in_fire) begin
            main_valid_d = Enable;
            main_data_d  = in_data;
         end else begin
            main_valid_d = Disable;
            main_data_d  = '0;
         end
      end else if (in_fire) begin
         if (!main_valid) begin
            main_valid_d = Enable;
            main_data_d  = in_data;
         end else begin
            skid_valid_d = Enable;
            skid_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= Disable;
         main_data  <= '0;
         skid_valid <= Disable;
         skid_data  <= '0;
      end else if (rdy) begin
         main_valid <= main_valid_d;
         main_data  <= main_data_d;
         skid_valid <= skid_valid_d;
         skid_data  <= skid_data_d;
      end
   end

   assign occupancy = 2'(main_valid) + 2'(skid_valid);
`else
   assign in_ready = (~main_valid | out_ready) & ~hold & ~flush & rdy & ~rst;

   always_comb begin
      main_valid_d = main_valid;
      main_data_d  = main_data;
      if (flush) begin
         main_valid_d = Disable;
         main_data_d  = '0;
      end else if (in_fire) begin
         main_valid_d = Enable;
         main_data_d  = in_data;
      end else if (out_fire) begin
         main_valid_d = Disable;
         main_data_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= Disable;
         main_data  <= '0;
      end else if (rdy) begin
         main_valid <= main_valid_d;
         main_data  <= main_data_d;
      end
   end

   assign occupancy = {1'b0, main_valid};
`endif

   assign out_valid = main_valid;
   assign out_data  = main_valid ? main_data : '0;

   pipe_sat_counter #(
      .CNT_W(CNT_W)
   ) u_bubble_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (rdy & ~main_valid),
      .count(bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

   localparam int unsigned DATA_W  = 102;
   localparam int unsigned STALL_W = 6;
   localparam int unsigned STAGE   = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned SNAP_W  = 3 + CNT_W + DATA_W;
   localparam int unsigned BUB_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               rdy = 1'b0;
   logic [STALL_W-1:0] stall_ctrler = '0;
   logic               flush = 1'b0;
   logic               in_valid = 1'b0;
   logic [DATA_W-1:0]  in_data = '0;
   logic               in_ready;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic               out_ready = 1'b0;
   logic [1:0]         occupancy;
   logic [CNT_W-1:0]   bubble_cnt;
   logic [SNAP_W-1:0]  dut_snap;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: ordered entries plus a saturating bubble count
   logic [DATA_W-1:0] mq[$];
   int unsigned       mbub = 0;

   pipe_stage_reg #(
      .DATA_W (DATA_W),
      .STALL_W(STALL_W),
      .STAGE  (STAGE),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .stall_ctrler(stall_ctrler),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .occupancy   (occupancy),
      .bubble_cnt  (bubble_cnt)
   );

   always #5 clk = ~clk;

   assign dut_snap = {out_valid, occupancy, bubble_cnt, out_data};

   function automatic logic [SNAP_W-1:0] model_snap();
      logic              v;
      logic [DATA_W-1:0] d;
      v = (mq.size() != 0);
      d = v ? mq[0] : '0;
      return {v, 2'(mq.size()), CNT_W'(mbub), d};
   endfunction

   function automatic logic model_in_ready();
      if (rst || !rdy || flush || stall_ctrler[STAGE]) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || out_ready;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[DATA_W-1:0];
   endfunction

   // Advance one clock; inputs are held across the edge, model updated from pre-edge state
   task automatic cycle();
      logic acc;
      logic emit;
      int   sz0;
      acc  = model_in_ready() && in_valid;
      emit = rdy && !flush && (mq.size() != 0) && out_ready;
      sz0  = mq.size();
      @(posedge clk);
      #1;
      if (rdy && !rst) begin
         if (sz0 == 0 && mbub < BUB_MAX) mbub++;
         if (flush) mq.delete();
         else begin
            if (emit) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic ordy);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic test_reset();
      rdy = 1'b1;
      #1 rst = 1'b1;
      #2;
      n_total++;
      if (dut_snap !== '0) $display("FAIL reset_state: got %h expected 0", dut_snap);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      mbub = 0;
      drive(1'b0, '0, 1'b1);
      repeat (5) cycle();
      n_total++;
      if (bubble_cnt !== CNT_W'(5) || out_valid !== 1'b0 || out_data !== '0)
         $display("FAIL idle_bubbles: got cnt=%0d v=%b d=%h expected cnt=5 v=0 d=0",
                  bubble_cnt, out_valid, out_data);
      else n_pass++;
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, DATA_W'(i), 1'b1);
         #1;
         n_total++;
         if (in_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready);
         else n_pass++;
         cycle();
         n_total++;
         if (out_valid !== 1'b1 || out_data !== DATA_W'(i))
            $display("FAIL stream_data_%0d: got v=%b d=%h expected v=1 d=%0h", i, out_valid, out_data, i);
         else n_pass++;
      end
      drive(1'b0, '0, 1'b1);
      cycle();
      n_total++;
      if (dut_snap !== model_snap()) $display("FAIL stream_drain: got %h expected %h", dut_snap, model_snap());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      drive(1'b1, DATA_W'(32'hA), 1'b0);
      cycle();
      drive(1'b1, DATA_W'(32'hB), 1'b0);
      #1;
      n_total++;
`ifdef PIPE_STAGE_SKID_EN
      if (in_ready !== 1'b1) $display("FAIL bp_ready_b: got %b expected 1", in_ready);
`else
      if (in_ready !== 1'b0) $display("FAIL bp_ready_b: got %b expected 0", in_ready);
`endif
      else n_pass++;
      cycle();
      n_total++;
`ifdef PIPE_STAGE_SKID_EN
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== DATA_W'(32'hA))
         $display("FAIL bp_full: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=a", occupancy, in_ready, out_data);
`else
      if (occupancy !== 2'd1 || out_data !== DATA_W'(32'hA))
         $display("FAIL bp_full: got occ=%0d d=%h expected occ=1 d=a", occupancy, out_data);
`endif
      else n_pass++;
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b0, '0, 1'b1);
`else
      drive(1'b1, DATA_W'(32'hB), 1'b1);
`endif
      cycle();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(32'hB) || dut_snap !== model_snap())
         $display("FAIL bp_second: got %h expected %h (data b)", dut_snap, model_snap());
      else n_pass++;
      drive(1'b0, '0, 1'b1);
      cycle();
      n_total++;
      if (out_valid !== 1'b0 || dut_snap !== model_snap())
         $display("FAIL bp_empty: got %h expected %h", dut_snap, model_snap());
      else n_pass++;
   endtask

   task automatic test_hold_bubble();
      drive(1'b1, DATA_W'(32'h5), 1'b0);
      cycle();
      stall_ctrler[STAGE] = 1'b1;
      drive(1'b1, DATA_W'(32'h77), 1'b1);
      #1;
      n_total++;
      if (in_ready !== 1'b0 || out_data !== DATA_W'(32'h5))
         $display("FAIL hold_head: got rdy=%b d=%h expected rdy=0 d=5", in_ready, out_data);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_total++;
         if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0 || dut_snap !== model_snap())
            $display("FAIL hold_bubble_%0d: got %h rdy=%b expected %h rdy=0", i, dut_snap, in_ready, model_snap());
         else n_pass++;
      end
      stall_ctrler = '0;
      drive(1'b0, '0, 1'b1);
   endtask

   task automatic test_flush();
      drive(1'b1, DATA_W'(32'h11), 1'b0);
      cycle();
      drive(1'b1, DATA_W'(32'h12), 1'b0);
      cycle();
      flush = 1'b1;
      drive(1'b1, DATA_W'(32'hC), 1'b1);
      #1;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", in_ready);
      else n_pass++;
      cycle();
      flush = 1'b0;
      n_total++;
      if (occupancy !== 2'd0 || dut_snap !== model_snap())
         $display("FAIL flush_clear: got %h expected %h", dut_snap, model_snap());
      else n_pass++;
      drive(1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_total++;
         if (out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL flush_no_c_%0d: got v=%b d=%h expected v=0 d=0", i, out_valid, out_data);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      mbub = 0;
      drive(1'b0, '0, 1'b1);
      repeat (BUB_MAX + 6) cycle();
      n_total++;
      if (bubble_cnt !== '1 || dut_snap !== model_snap())
         $display("FAIL bubble_saturate: got %h expected %h (cnt all-ones)", dut_snap, model_snap());
      else n_pass++;
   endtask

   task automatic test_freeze_async_reset();
      drive(1'b1, DATA_W'(32'h21), 1'b0);
      cycle();
      drive(1'b1, DATA_W'(32'h22), 1'b0);
      cycle();
      rdy = 1'b0;
      drive(1'b1, DATA_W'(32'h23), 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (in_ready !== 1'b0) $display("FAIL freeze_ready_%0d: got %b expected 0", i, in_ready);
         else n_pass++;
         cycle();
         n_total++;
         if (dut_snap !== model_snap())
            $display("FAIL freeze_state_%0d: got %h expected %h", i, dut_snap, model_snap());
         else n_pass++;
      end
      rdy = 1'b1;
      cycle();
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (dut_snap !== '0 || in_ready !== 1'b0)
         $display("FAIL async_reset: got %h rdy=%b expected 0 rdy=0", dut_snap, in_ready);
      else n_pass++;
      mq.delete();
      mbub = 0;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, '0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rdy          = ($urandom_range(9) != 0);
         stall_ctrler = STALL_W'($urandom());
         if ($urandom_range(2) != 0) stall_ctrler[STAGE] = 1'b0;
         flush        = ($urandom_range(19) == 0);
         drive(($urandom_range(9) < 7), rand_data(), ($urandom_range(9) < 6));
         #1;
         n_total++;
         if (in_ready !== model_in_ready())
            $display("FAIL rand_ready_%0d: got %b expected %b", i, in_ready, model_in_ready());
         else n_pass++;
         cycle();
         n_total++;
         if (dut_snap !== model_snap())
            $display("FAIL rand_state_%0d: got %h expected %h", i, dut_snap, model_snap());
         else n_pass++;
      end
      rdy = 1'b1;
      flush = 1'b0;
      stall_ctrler = '0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_hold_bubble();
      test_flush();
      test_saturation();
      test_freeze_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
